// File: rtl/bus_dtack_responder_if.sv
// 68k bus-side handshake pins shared by a bus master and the DTACK responder.
// The master drives the strobes and the responder drives the DTACK/BERR pad levels and enables.
interface bus_dtack_responder_if;
    logic nAs;
    logic nUds;
    logic nLds;
    logic rw;
    logic nDtack;
    logic dtackOe;
    logic nBerr;
    logic berrOe;

    modport master (
        output nAs, nUds, nLds, rw,
        input  nDtack, dtackOe, nBerr, berrOe
    );

    modport slave (
        input  nAs, nUds, nLds, rw,
        output nDtack, dtackOe, nBerr, berrOe
    );
endinterface

// File: rtl/bus_dtack_responder.sv
// Slave end of the 68k asynchronous bus handshake: answers a selected access with DTACK
// after a tunable number of MCCLK falling edges, or with BERR when the device never gets ready.
module bus_dtack_responder #(
    parameter int RELEASE_CYCLES = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                        i_sysclk,
    input  logic                        i_reset,
    input  logic                        i_mcclkRising,
    input  logic                        i_mcclkFalling,
    input  logic                        i_select,
    input  logic                        i_ready,
    input  logic [3:0]                  i_waitStates,
    output logic                        o_accessStart,
    output logic                        o_accessWrite,
    output logic [1:0]                  o_byteEn,
    output logic                        o_accessAbort,
    bus_dtack_responder_if.slave        io_bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ASSERT,
        ST_BERR,
        ST_RELEASE
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM  = 8'(TIMEOUT);
    localparam logic [7:0] RELEASE_LAST = 8'(RELEASE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_asSync;
    logic [1:0] r_udsSync;
    logic [1:0] r_ldsSync;
    logic [1:0] r_rwSync;
    logic [3:0] r_wsCnt;
    logic [7:0] r_toCnt;
    logic [7:0] r_relCnt;
    logic       r_accessStart;
    logic       r_accessAbort;
    logic       r_accessWrite;
    logic [1:0] r_byteEn;
    logic       r_nDtack;
    logic       r_dtackOe;
    logic       r_nBerr;
    logic       r_berrOe;

    logic       w_sAs;
    logic       w_sUds;
    logic       w_sLds;
    logic       w_sRw;
    logic [3:0] w_wsNext;
    logic [7:0] w_toNext;

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_asSync  <= 2'b11;
            r_udsSync <= 2'b11;
            r_ldsSync <= 2'b11;
            r_rwSync  <= 2'b11;
        end else begin
            r_asSync  <= {r_asSync[0], io_bus.nAs};
            r_udsSync <= {r_udsSync[0], io_bus.nUds};
            r_ldsSync <= {r_ldsSync[0], io_bus.nLds};
            r_rwSync  <= {r_rwSync[0], io_bus.rw};
        end
    end

    assign w_sAs  = r_asSync[1];
    assign w_sUds = r_udsSync[1];
    assign w_sLds = r_ldsSync[1];
    assign w_sRw  = r_rwSync[1];

    // Counts include a falling edge seen this cycle, so DTACK/BERR can fire on that very edge.
    assign w_wsNext = (i_mcclkFalling && (r_wsCnt != 4'hF)) ? r_wsCnt + 4'd1 : r_wsCnt;
    assign w_toNext = (i_mcclkFalling && (r_toCnt != 8'hFF)) ? r_toCnt + 8'd1 : r_toCnt;

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_wsCnt       <= 4'd0;
            r_toCnt       <= 8'd0;
            r_relCnt      <= 8'd0;
            r_accessStart <= 1'b0;
            r_accessAbort <= 1'b0;
            r_accessWrite <= 1'b0;
            r_byteEn      <= 2'b00;
            r_nDtack      <= 1'b1;
            r_dtackOe     <= 1'b0;
            r_nBerr       <= 1'b1;
            r_berrOe      <= 1'b0;
        end else begin
            r_accessStart <= 1'b0;
            r_accessAbort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_sAs && (!w_sUds || !w_sLds) && i_select) begin
                        r_accessStart <= 1'b1;
                        r_accessWrite <= ~w_sRw;
                        r_byteEn      <= {~w_sUds, ~w_sLds};
                        r_wsCnt       <= 4'd0;
                        r_toCnt       <= 8'd0;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_wsCnt <= w_wsNext;
                    r_toCnt <= w_toNext;
                    if (w_sAs) begin
                        r_accessAbort <= 1'b1;
                        r_accessWrite <= 1'b0;
                        r_byteEn      <= 2'b00;
                        r_state       <= ST_IDLE;
                    end else if ((w_wsNext >= i_waitStates) && i_ready) begin
                        r_nDtack  <= 1'b0;
                        r_dtackOe <= 1'b1;
                        r_state   <= ST_ASSERT;
                    end else if (w_toNext >= TIMEOUT_LIM) begin
                        r_nBerr  <= 1'b0;
                        r_berrOe <= 1'b1;
                        r_state  <= ST_BERR;
                    end
                end
                ST_ASSERT: begin
                    if (w_sAs) begin
                        r_nDtack <= 1'b1;
                        r_relCnt <= 8'd0;
                        r_state  <= ST_RELEASE;
                    end
                end
                ST_BERR: begin
                    if (w_sAs) begin
                        r_nBerr  <= 1'b1;
                        r_relCnt <= 8'd0;
                        r_state  <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Active negation: whichever pad was asserted is held high before letting go.
                    if (r_relCnt == RELEASE_LAST) begin
                        r_dtackOe     <= 1'b0;
                        r_berrOe      <= 1'b0;
                        r_accessWrite <= 1'b0;
                        r_byteEn      <= 2'b00;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_relCnt <= r_relCnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_accessStart = r_accessStart;
    assign o_accessAbort = r_accessAbort;
    assign o_accessWrite = r_accessWrite;
    assign o_byteEn      = r_byteEn;

    // Pads float as soon as reset is seen, without waiting for the registers to clear.
    assign io_bus.nDtack  = r_nDtack;
    assign io_bus.dtackOe = r_dtackOe && !i_reset;
    assign io_bus.nBerr   = r_nBerr;
    assign io_bus.berrOe  = r_berrOe && !i_reset;

    assert property (@(posedge i_sysclk) disable iff (i_reset) !(i_mcclkRising && i_mcclkFalling));

endmodule

// File: tb/tb_bus_dtack_responder.sv
// Randomized bus-master bench for bus_dtack_responder: the driver predicts every DUT event
// from the handshake rules into a queue, and a negedge monitor pops and compares each observed event.
module tb_bus_dtack_responder;

    localparam int RELEASE_CYCLES = 4;
    localparam int TIMEOUT        = 64;
    localparam int MC_PERIOD      = 6;

    typedef enum int {
        EV_START, EV_ABORT, EV_DTACK, EV_DTACK_REL, EV_DTACK_OFF,
        EV_BERR, EV_BERR_REL, EV_BERR_OFF
    } evKind_t;

    typedef struct {
        evKind_t    kind;
        int         cycle;
        logic       write;
        logic [1:0] byteEn;
        bit         checkClear;
    } expEvent_t;

    expEvent_t expQ[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mcclkRising = 1'b0;
    logic       mcclkFalling = 1'b0;
    logic       select = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] waitStates = 4'd0;
    logic       accessStart;
    logic       accessWrite;
    logic [1:0] byteEn;
    logic       accessAbort;

    int  cycle = 0;
    int  checks = 0;
    int  errors = 0;
    bit  monActive = 1'b0;
    logic prevDtackOe = 1'b0;
    logic prevNDtack = 1'b1;
    logic prevBerrOe = 1'b0;
    logic prevNBerr = 1'b1;

    bus_dtack_responder_if bus();

    bus_dtack_responder #(
        .RELEASE_CYCLES(RELEASE_CYCLES),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .i_sysclk      (clk),
        .i_reset       (reset),
        .i_mcclkRising (mcclkRising),
        .i_mcclkFalling(mcclkFalling),
        .i_select      (select),
        .i_ready       (ready),
        .i_waitStates  (waitStates),
        .o_accessStart (accessStart),
        .o_accessWrite (accessWrite),
        .o_byteEn      (byteEn),
        .o_accessAbort (accessAbort),
        .io_bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // MCCLK falls are sampled on every posedge whose number is a multiple of MC_PERIOD.
    always @(posedge clk) begin
        #1;
        mcclkFalling = (((cycle + 1) % MC_PERIOD) == 0);
        mcclkRising  = (((cycle + 1) % MC_PERIOD) == (MC_PERIOD / 2));
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Posedge at which the n-th MCCLK fall strictly after edge c0 is sampled (c0 itself for n=0).
    function automatic int nthFallAfter(input int c0, input int n);
        if (n == 0) return c0;
        return ((c0 / MC_PERIOD) + 1) * MC_PERIOD + (n - 1) * MC_PERIOD;
    endfunction

    function automatic void pushEv(input evKind_t k, input int c, input logic w,
                                   input logic [1:0] b, input bit clr);
        expEvent_t e;
        e.kind = k;
        e.cycle = c;
        e.write = w;
        e.byteEn = b;
        e.checkClear = clr;
        expQ.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".accessStart"}, int'(accessStart), 0);
        checkOutput({tag, ".accessAbort"}, int'(accessAbort), 0);
        checkOutput({tag, ".accessWrite"}, int'(accessWrite), 0);
        checkOutput({tag, ".byteEn"}, int'(byteEn), 0);
        checkOutput({tag, ".nDtack"}, int'(bus.nDtack), 1);
        checkOutput({tag, ".dtackOe"}, int'(bus.dtackOe), 0);
        checkOutput({tag, ".nBerr"}, int'(bus.nBerr), 1);
        checkOutput({tag, ".berrOe"}, int'(bus.berrOe), 0);
    endtask

    task automatic scoreEvent(input evKind_t kind);
        expEvent_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected.%s at cycle %0d: got event, expected none", kind.name(), cycle);
            return;
        end
        e = expQ.pop_front();
        checkOutput($sformatf("%s.kind", kind.name()), int'(kind), int'(e.kind));
        checkOutput($sformatf("%s.cycle", kind.name()), cycle, e.cycle);
        if (kind == EV_START) begin
            checkOutput("start.write", int'(accessWrite), int'(e.write));
            checkOutput("start.byteEn", int'(byteEn), int'(e.byteEn));
        end
        if (e.checkClear) begin
            checkOutput($sformatf("%s.writeCleared", kind.name()), int'(accessWrite), 0);
            checkOutput($sformatf("%s.byteEnCleared", kind.name()), int'(byteEn), 0);
        end
    endtask

    always @(negedge clk) begin
        if (monActive) begin
            if (accessStart) scoreEvent(EV_START);
            if (accessAbort) scoreEvent(EV_ABORT);
            if (bus.dtackOe && !prevDtackOe) begin
                scoreEvent(EV_DTACK);
                checkOutput("dtack.level", int'(bus.nDtack), 0);
            end
            if (bus.dtackOe && prevDtackOe && bus.nDtack && !prevNDtack) scoreEvent(EV_DTACK_REL);
            if (!bus.dtackOe && prevDtackOe) scoreEvent(EV_DTACK_OFF);
            if (bus.berrOe && !prevBerrOe) begin
                scoreEvent(EV_BERR);
                checkOutput("berr.level", int'(bus.nBerr), 0);
            end
            if (bus.berrOe && prevBerrOe && bus.nBerr && !prevNBerr) scoreEvent(EV_BERR_REL);
            if (!bus.berrOe && prevBerrOe) scoreEvent(EV_BERR_OFF);
            checkOutput("oe.exclusive", int'(bus.dtackOe && bus.berrOe), 0);
        end
        prevDtackOe = bus.dtackOe;
        prevNDtack  = bus.nDtack;
        prevBerrOe  = bus.berrOe;
        prevNBerr   = bus.nBerr;
    end

    // One bus cycle. readyDelay: 0 = never ready, -1 = ready exactly at the timeout edge.
    // abortOffset > 0 negates nAS so the DUT sees it abortOffset edges after ACCESS_START.
    task automatic applyStimulus(input bit sel, input bit rw, input logic [1:0] be,
                                 input int strobeDelay, input int ws, input int readyDelay,
                                 input int abortOffset, input int hold);
        int t1, c0, rdy, readyCycle, dtackEdge, berrEdge, evEdge, relEdge, xRel, endCycle;
        bit isBerr;
        nextCycle();
        ready = 1'b0;
        waitStates = 4'(ws);
        select = sel;
        bus.rw = rw;
        bus.nAs = 1'b0;
        t1 = cycle + strobeDelay;
        c0 = t1 + 3;
        berrEdge = nthFallAfter(c0, TIMEOUT);
        rdy = (readyDelay < 0) ? (berrEdge - c0) : readyDelay;
        readyCycle = (rdy > 0) ? (c0 + rdy - 1) : -1;
        dtackEdge = (rdy > 0) ? maxInt(c0 + rdy, nthFallAfter(c0, ws)) : 0;
        isBerr = (rdy == 0) || (dtackEdge > berrEdge);
        evEdge = isBerr ? berrEdge : dtackEdge;
        relEdge = (abortOffset > 0) ? (c0 + abortOffset) : (evEdge + hold + 3);
        if (!sel) begin
            relEdge = t1 + 12;
            endCycle = relEdge + 4;
        end else if (relEdge <= evEdge) begin
            pushEv(EV_START, c0, ~rw, be, 1'b0);
            pushEv(EV_ABORT, relEdge, 1'b0, 2'b00, 1'b1);
            endCycle = relEdge + 2;
        end else begin
            pushEv(EV_START, c0, ~rw, be, 1'b0);
            pushEv(isBerr ? EV_BERR : EV_DTACK, evEdge, 1'b0, 2'b00, 1'b0);
            pushEv(isBerr ? EV_BERR_REL : EV_DTACK_REL, relEdge, 1'b0, 2'b00, 1'b0);
            pushEv(isBerr ? EV_BERR_OFF : EV_DTACK_OFF, relEdge + RELEASE_CYCLES, 1'b0, 2'b00, 1'b1);
            endCycle = relEdge + RELEASE_CYCLES + 1;
        end
        xRel = relEdge - 3;
        forever begin
            if (cycle == t1) begin
                bus.nUds = ~be[1];
                bus.nLds = ~be[0];
            end
            if (cycle == readyCycle) ready = 1'b1;
            if (cycle == xRel) begin
                bus.nAs = 1'b1;
                bus.nUds = 1'b1;
                bus.nLds = 1'b1;
                select = 1'b0;
            end
            if (cycle >= endCycle) break;
            nextCycle();
        end
        ready = 1'b0;
    endtask

    task automatic resetDuringAssert();
        int c0, n;
        nextCycle();
        ready = 1'b1;
        waitStates = 4'd0;
        select = 1'b1;
        bus.rw = 1'b0;
        bus.nAs = 1'b0;
        bus.nUds = 1'b0;
        bus.nLds = 1'b0;
        c0 = cycle + 3;
        n = c0 + 4;
        pushEv(EV_START, c0, 1'b1, 2'b11, 1'b0);
        pushEv(EV_DTACK, c0 + 1, 1'b0, 2'b00, 1'b0);
        pushEv(EV_DTACK_OFF, n, 1'b0, 2'b00, 1'b0);
        while (cycle < n) nextCycle();
        reset = 1'b1;
        bus.nAs = 1'b1;
        bus.nUds = 1'b1;
        bus.nLds = 1'b1;
        select = 1'b0;
        ready = 1'b0;
        nextCycle();
        checkIdleOutputs("midReset");
        nextCycle();
        reset = 1'b0;
        repeat (2) nextCycle();
    endtask

    initial begin
        bus.nAs = 1'b1;
        bus.nUds = 1'b1;
        bus.nLds = 1'b1;
        bus.rw = 1'b1;
        repeat (3) nextCycle();
        checkIdleOutputs("reset");
        nextCycle();
        reset = 1'b0;
        monActive = 1'b1;
        repeat (2) nextCycle();

        applyStimulus(1'b1, 1'b1, 2'b01, 0, 2, 1, 0, 3);
        applyStimulus(1'b1, 1'b0, 2'b11, 0, 0, 10, 0, 2);
        applyStimulus(1'b1, 1'b1, 2'b10, 0, 3, 0, 0, 1);
        applyStimulus(1'b1, 1'b1, 2'b11, 0, 5, 0, 5, 0);
        resetDuringAssert();
        applyStimulus(1'b1, 1'b1, 2'b11, 0, 1, 2, 0, 0);
        applyStimulus(1'b0, 1'b1, 2'b11, 0, 0, 1, 0, 2);
        applyStimulus(1'b1, 1'b0, 2'b01, 4, 1, 3, 0, 2);
        applyStimulus(1'b1, 1'b1, 2'b11, 0, 0, -1, 0, 1);
        applyStimulus(1'b1, 1'b0, 2'b10, 1, 15, 1, 0, 4);

        for (int i = 0; i < 40; i++) begin
            bit sel, rw;
            logic [1:0] be;
            int ws, rdy, ab;
            sel = ($urandom_range(0, 9) != 0);
            rw = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(1, 3));
            ws = $urandom_range(0, 15);
            rdy = ($urandom_range(0, 99) < 15) ? 0 : $urandom_range(1, 40);
            ab = ($urandom_range(0, 99) < 15) ? $urandom_range(1, 30) : 0;
            applyStimulus(sel, rw, be, $urandom_range(0, 3), ws, rdy, ab, $urandom_range(0, 5));
        end

        repeat (10) nextCycle();
        checkOutput("queue.empty", expQ.size(), 0);
        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
